// File: rtl/i_cache_if.sv
// i_cache_if: i-cache to main-memory request channel (req/address out, ack/data in).
interface i_cache_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned BEAT_W = 16
);
  logic              req;
  logic [ADDR_W-1:0] address;
  logic              ack;
  logic [BEAT_W-1:0] data;

  modport master (output req, address, input ack, data);
  modport slave  (input req, address, output ack, data);
endinterface

// File: rtl/i_cache.sv
// i_cache: direct-mapped read-only instruction cache with combinational lookup
// and a request/ack + multi-beat fill toward main memory.
// Optional: define I_CACHE_STATS_EN to add saturating hit/miss counters.
module i_cache #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned BLOCK_W = 64,
  parameter int unsigned BEAT_W  = 16,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned LINES   = 8
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               i_fetch_en,
  input  logic [ADDR_W-1:0]  i_pc,
  input  logic               i_flush,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_hit,
  output logic               o_stall,
  i_cache_if.master          bus
`ifdef I_CACHE_STATS_EN
  ,
  output logic [31:0]        o_hit_count,
  output logic [31:0]        o_miss_count
`endif
);

  localparam int unsigned WORDS     = BLOCK_W / INSTR_W;
  localparam int unsigned WORD_BITS = $clog2(WORDS);
  localparam int unsigned WB_W      = (WORD_BITS > 0) ? WORD_BITS : 1;
  localparam int unsigned IDX_BITS  = $clog2(LINES);
  localparam int unsigned IDX_W     = (IDX_BITS > 0) ? IDX_BITS : 1;
  localparam int unsigned TAG_W     = ADDR_W - WORD_BITS - IDX_BITS;
  localparam int unsigned BEATS     = BLOCK_W / BEAT_W;
  localparam int unsigned CNT_W     = $clog2(BEATS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQUEST, S_FILL} state_t;

  state_t             r_state;
  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [BLOCK_W-1:0] r_data [LINES];
  logic [BLOCK_W-1:0] r_fill;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_req;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_poison;

  logic [ADDR_W-1:0]  w_block;
  logic [IDX_W-1:0]   w_idx;
  logic [WB_W-1:0]    w_word;
  logic [TAG_W-1:0]   w_tag;
  logic [IDX_W-1:0]   w_fidx;
  logic [TAG_W-1:0]   w_ftag;
  logic               w_hit;
  logic               w_launch;
  logic               w_last;
  logic [BLOCK_W-1:0] w_fill_next;

  // Split the fetch PC and the in-flight miss address into line fields.
  always_comb begin
    w_block = i_pc >> WORD_BITS;
    w_idx   = (LINES == 1) ? '0 : IDX_W'(w_block);
    w_word  = (WORDS == 1) ? '0 : WB_W'(i_pc);
    w_tag   = TAG_W'(w_block >> IDX_BITS);
    w_fidx  = (LINES == 1) ? '0 : IDX_W'(r_addr);
    w_ftag  = TAG_W'(r_addr >> IDX_BITS);
  end

  // Same-cycle lookup, miss launch decision and fill-buffer merge.
  always_comb begin
    w_hit       = (r_state == S_IDLE) && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    o_hit       = w_hit;
    o_instr     = r_data[w_idx][32'(w_word) * INSTR_W +: INSTR_W];
    o_stall     = i_fetch_en && !w_hit;
    w_launch    = (r_state == S_IDLE) && i_fetch_en && !w_hit && !i_flush;
    w_last      = (r_state == S_FILL) && (r_cnt == CNT_LAST);
    w_fill_next = r_fill;
    w_fill_next[32'(r_cnt) * BEAT_W +: BEAT_W] = bus.data;
  end

  assign bus.req     = r_req;
  assign bus.address = r_addr;

  // Miss FSM: request until acked, then collect beats; flush poisons a fill in flight.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state  <= S_IDLE;
      r_valid  <= '0;
      r_req    <= 1'b0;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_poison <= 1'b0;
    end else begin
      if (i_flush) r_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_state  <= S_REQUEST;
            r_req    <= 1'b1;
            r_addr   <= w_block;
            r_poison <= 1'b0;
          end
        end
        S_REQUEST: begin
          if (i_flush) r_poison <= 1'b1;
          if (bus.ack) begin
            r_state <= S_FILL;
            r_req   <= 1'b0;
            r_cnt   <= '0;
          end
        end
        S_FILL: begin
          if (i_flush) r_poison <= 1'b1;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_state <= S_IDLE;
            if (!i_flush && !r_poison) r_valid[w_fidx] <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  // Fill buffer and line/tag arrays; these carry no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_FILL) r_fill <= w_fill_next;
    if (n_rst && w_last) begin
      r_data[w_fidx] <= w_fill_next;
      r_tag[w_fidx]  <= w_ftag;
    end
  end

`ifdef I_CACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  // Saturating usage counters; flush leaves them untouched.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (i_fetch_en && w_hit && (r_hit_count != 32'hFFFF_FFFF))
        r_hit_count <= r_hit_count + 32'd1;
      if (w_launch && (r_miss_count != 32'hFFFF_FFFF))
        r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_i_cache.sv
// tb_i_cache: directed scenarios plus randomized traffic, checked every cycle
// against a block-level cache model and a simple memory responder.
module tb_i_cache;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        fetch_en;
  logic [15:0] pc;
  logic        flush;
  logic        ack_en;
  logic [15:0] instr;
  logic        hit;
  logic        stall;
`ifdef I_CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] mem [256];
  bit          ag_fill = 1'b0;
  int          ag_beat = 0;

  i_cache_if #(.ADDR_W(16), .BEAT_W(16)) bus ();

  i_cache dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .i_fetch_en (fetch_en),
    .i_pc       (pc),
    .i_flush    (flush),
    .o_instr    (instr),
    .o_hit      (hit),
    .o_stall    (stall),
    .bus        (bus)
`ifdef I_CACHE_STATS_EN
    ,
    .o_hit_count  (hit_count),
    .o_miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  // Memory responder: ack is a raw strobe (ignored unless req), beats follow the ack cycle.
  assign bus.ack  = ack_en;
  assign bus.data = ag_fill ? mem[(int'(bus.address) * 4 + ag_beat) & 255] : 16'hDEAD;

  always @(posedge clk) begin
    if (!n_rst) begin
      ag_fill <= 1'b0;
    end else if (ag_fill) begin
      if (ag_beat == 3) ag_fill <= 1'b0;
      ag_beat <= ag_beat + 1;
    end else if (bus.req === 1'b1 && ack_en) begin
      ag_fill <= 1'b1;
      ag_beat <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Block-level model: which block each line holds, plus the outstanding miss.
  bit          m_live = 1'b0;
  int          m_vblk [8];
  logic [15:0] m_data [8][4];
  bit          m_pending, m_acked, m_poison;
  int          m_blk, m_beats;
  longint      m_hits, m_misses;

  always @(negedge clk) begin : cmp
    int  blk, idx, wd, fidx;
    bit  ehit;
    blk  = int'(pc) / 4;
    idx  = blk % 8;
    wd   = int'(pc) % 4;
    ehit = !m_pending && (m_vblk[idx] == blk);
    if (m_live) begin
      chk("hit", 32'(hit), 32'(ehit));
      chk("stall", 32'(stall), 32'(fetch_en && !ehit));
      chk("mem_req", 32'(bus.req), 32'(m_pending && !m_acked));
      if (m_pending) chk("mem_address", 32'(bus.address), 32'(m_blk));
      if (ehit) chk("instr", 32'(instr), 32'(m_data[idx][wd]));
`ifdef I_CACHE_STATS_EN
      chk("hit_count", hit_count, 32'(m_hits));
      chk("miss_count", miss_count, 32'(m_misses));
`endif
    end
    if (!n_rst) begin
      for (int i = 0; i < 8; i++) m_vblk[i] = -1;
      m_pending = 1'b0;
      m_acked   = 1'b0;
      m_hits    = 0;
      m_misses  = 0;
      m_live    = 1'b1;
    end else if (m_live) begin
      if (fetch_en && ehit && m_hits < 64'hFFFF_FFFF) m_hits++;
      if (m_pending && !m_acked) begin
        if (flush) m_poison = 1'b1;
        if (ack_en) begin
          m_acked = 1'b1;
          m_beats = 0;
        end
      end else if (m_pending) begin
        if (flush) m_poison = 1'b1;
        m_beats++;
        if (m_beats == 4) begin
          m_pending = 1'b0;
          fidx = m_blk % 8;
          if (!m_poison) begin
            m_vblk[fidx] = m_blk;
            for (int w = 0; w < 4; w++) m_data[fidx][w] = mem[(m_blk * 4 + w) & 255];
          end else begin
            m_vblk[fidx] = -1;
          end
        end
      end else if (fetch_en && !ehit && !flush) begin
        m_pending = 1'b1;
        m_acked   = 1'b0;
        m_poison  = 1'b0;
        m_blk     = blk;
        if (m_misses < 64'hFFFF_FFFF) m_misses++;
      end
      if (flush) for (int i = 0; i < 8; i++) m_vblk[i] = -1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call in a REQUEST cycle: hold ack off for 'delay' cycles, ack, then take four beats.
  task automatic run_fill(input int delay, input logic [15:0] addr);
    for (int i = 0; i < delay; i++) begin
      ack_en = 1'b0;
      #1;
      chk("wait_req", 32'(bus.req), 32'd1);
      chk("wait_addr", 32'(bus.address), 32'(addr));
      tick();
    end
    ack_en = 1'b1;
    #1;
    chk("ack_req", 32'(bus.req), 32'd1);
    chk("ack_addr", 32'(bus.address), 32'(addr));
    tick();
    ack_en = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    n_rst = 1'b0; fetch_en = 1'b0; pc = '0; flush = 1'b0; ack_en = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    mem[32] = 16'hAAAA; mem[33] = 16'hBBBB; mem[34] = 16'hCCCC; mem[35] = 16'hDDDD;
    tick(); tick();
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_req", 32'(bus.req), 32'd0);
    chk("rst_addr", 32'(bus.address), 32'd0);

    // Cold miss on pc 0.
    n_rst = 1'b1; fetch_en = 1'b1; pc = 16'h0000;
    #1;
    chk("cold_hit", 32'(hit), 32'd0);
    chk("cold_stall", 32'(stall), 32'd1);
    tick();
    chk("cold_req", 32'(bus.req), 32'd1);
    run_fill(0, 16'h0000);
    chk("cold_fill_hit", 32'(hit), 32'd1);
    chk("cold_instr0", 32'(instr), 32'h1111);
    pc = 16'h0003;
    #1;
    chk("cold_instr3", 32'(instr), 32'h4444);
    chk("cold_noreq", 32'(bus.req), 32'd0);

    // Conflict eviction at index 0.
    pc = 16'h0020;
    #1;
    chk("conf_miss", 32'(hit), 32'd0);
    tick();
    run_fill(0, 16'h0008);
    chk("conf_instr", 32'(instr), 32'hAAAA);
    pc = 16'h0000;
    #1;
    chk("conf_evicted", 32'(hit), 32'd0);
    tick();
    run_fill(0, 16'h0000);
    chk("conf_back", 32'(instr), 32'h1111);

    // Delayed ack.
    pc = 16'h0045;
    tick();
    run_fill(5, 16'h0011);
    chk("dly_hit", 32'(hit), 32'd1);
    chk("dly_instr", 32'(instr), 32'(mem[8'h45]));

    // Flush during a fill poisons it.
    fetch_en = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; fetch_en = 1'b1; pc = 16'h0000;
    tick();
    ack_en = 1'b1;
    tick();
    ack_en = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("fl_hit", 32'(hit), 32'd0);
    chk("fl_stall", 32'(stall), 32'd1);
    tick();
    run_fill(0, 16'h0000);
    chk("fl_refill", 32'(hit), 32'd1);

    // Reset during a fill.
    pc = 16'h0010;
    tick();
    ack_en = 1'b1;
    tick();
    ack_en = 1'b0;
    tick();
    n_rst = 1'b0; pc = 16'h0000;
    tick();
    chk("rstf_req", 32'(bus.req), 32'd0);
    chk("rstf_hit", 32'(hit), 32'd0);
    n_rst = 1'b1;
    tick();
    run_fill(0, 16'h0000);
    repeat (3) tick();
    chk("post_hit", 32'(hit), 32'd1);
`ifdef I_CACHE_STATS_EN
    chk("stat_miss", miss_count, 32'd1);
    chk("stat_hit", hit_count, 32'd3);
`endif

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      n_rst    = ($urandom_range(0, 199) != 0);
      flush    = ($urandom_range(0, 39) == 0);
      fetch_en = ($urandom_range(0, 9) < 8);
      ack_en   = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 1) != 0) pc = 16'($urandom_range(0, 255));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
